// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with RUN/STALL/HALT control and IF/ID flush/hold.
// Optional redirect/stall statistics counters enabled by PC_SEQ_STATS_EN.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          PC_STEP     = 1,
   parameter int          STALL_LIMIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] npc_in,
   input  logic        jmp,
   input  logic        correct_b,
   input  logic        stall,
   input  logic        halt_req,
   input  logic        go,
   output logic [31:0] pc,
   output logic [31:0] pc_plus,
   output logic        pc_we,
   output logic        if_id_flush,
   output logic        if_id_hold,
   output logic        halted,
   output logic        stall_err,
   output logic [15:0] redirect_cnt,
   output logic [15:0] stall_cnt
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [31:0] STEP  = 32'(PC_STEP);
   localparam logic [5:0]  LIMIT = 6'(STALL_LIMIT);

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [31:0] pc_nxt;
   logic [4:0]  run_cnt;
   logic        stalling;

   assign pc_plus = pc + STEP;
   assign halted  = (state == ST_HALT);

   // Priority: halt_req > stall > redirect > sequential; HALT ignores everything but go.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      pc_we       = 1'b0;
      if_id_flush = 1'b0;
      if_id_hold  = 1'b0;
      stalling    = 1'b0;
      if (state == ST_HALT) begin
         if_id_flush = 1'b1;
         if (go) state_nxt = ST_RUN;
      end else if (halt_req) begin
         state_nxt   = ST_HALT;
         if_id_flush = 1'b1;
      end else if (stall) begin
         state_nxt  = ST_STALL;
         if_id_hold = 1'b1;
         stalling   = 1'b1;
      end else begin
         state_nxt = ST_RUN;
         pc_we     = 1'b1;
         if (jmp || correct_b) begin
            pc_nxt      = npc_in;
            if_id_flush = 1'b1;
         end else begin
            pc_nxt = pc_plus;
         end
      end
      if (!rst_n) begin
         pc_we       = 1'b0;
         if_id_flush = 1'b1;
         if_id_hold  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         pc        <= RESET_PC;
         run_cnt   <= 5'd0;
         stall_err <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (stalling) begin
            if (run_cnt != 5'h1f) run_cnt <= run_cnt + 5'd1;
            if (({1'b0, run_cnt} + 6'd1) >= LIMIT) stall_err <= 1'b1;
         end else begin
            run_cnt <= 5'd0;
         end
      end
   end

`ifdef PC_SEQ_STATS_EN
   logic redirect_take;
   // pc_we together with flush only occurs on a taken redirect.
   assign redirect_take = pc_we && if_id_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_cnt <= 16'h0;
         stall_cnt    <= 16'h0;
      end else begin
         if (redirect_take && redirect_cnt != 16'hFFFF) redirect_cnt <= redirect_cnt + 16'h1;
         if (stalling && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'h1;
      end
   end
`else
   assign redirect_cnt = 16'h0;
   assign stall_cnt    = 16'h0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed bench for pc_sequencer with a behavioural reference model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] npc_in = 32'h0;
   logic        jmp = 1'b0, correct_b = 1'b0, stall = 1'b0, halt_req = 1'b0, go = 1'b0;
   logic [31:0] pc, pc_plus;
   logic        pc_we, if_id_flush, if_id_hold, halted, stall_err;
   logic [15:0] redirect_cnt, stall_cnt;

   int n_checks = 0;
   int n_err    = 0;

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .npc_in(npc_in), .jmp(jmp), .correct_b(correct_b),
      .stall(stall), .halt_req(halt_req), .go(go), .pc(pc), .pc_plus(pc_plus),
      .pc_we(pc_we), .if_id_flush(if_id_flush), .if_id_hold(if_id_hold),
      .halted(halted), .stall_err(stall_err), .redirect_cnt(redirect_cnt),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: fetch address, halt flag, current stall run length, sticky error, statistics.
   logic [31:0] m_pc = 32'h0;
   bit          m_halt = 1'b0;
   int          m_run = 0;
   bit          m_err = 1'b0;
   int          m_rcnt = 0;
   int          m_scnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= 32'h0; m_halt <= 1'b0; m_run <= 0; m_err <= 1'b0; m_rcnt <= 0; m_scnt <= 0;
      end else if (m_halt) begin
         if (go) m_halt <= 1'b0;
         m_run <= 0;
      end else if (halt_req) begin
         m_halt <= 1'b1;
         m_run  <= 0;
      end else if (stall) begin
         m_run <= m_run + 1;
         if (m_run + 1 >= 15) m_err <= 1'b1;
         if (m_scnt < 65535) m_scnt <= m_scnt + 1;
      end else if (jmp || correct_b) begin
         m_pc  <= npc_in;
         m_run <= 0;
         if (m_rcnt < 65535) m_rcnt <= m_rcnt + 1;
      end else begin
         m_pc  <= m_pc + 32'd1;
         m_run <= 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic e_we, e_fl, e_hd, e_hlt;
      logic [15:0] e_r, e_s;
      e_hlt = rst_n && m_halt;
      if (!rst_n)                 begin e_we = 0; e_fl = 1; e_hd = 0; end
      else if (m_halt || halt_req) begin e_we = 0; e_fl = 1; e_hd = 0; end
      else if (stall)             begin e_we = 0; e_fl = 0; e_hd = 1; end
      else if (jmp || correct_b)  begin e_we = 1; e_fl = 1; e_hd = 0; end
      else                        begin e_we = 1; e_fl = 0; e_hd = 0; end
`ifdef PC_SEQ_STATS_EN
      e_r = 16'(m_rcnt); e_s = 16'(m_scnt);
`else
      e_r = 16'h0; e_s = 16'h0;
`endif
      chk("pc", pc, m_pc);
      chk("pc_plus", pc_plus, m_pc + 32'd1);
      chk("pc_we", 32'(pc_we), 32'(e_we));
      chk("if_id_flush", 32'(if_id_flush), 32'(e_fl));
      chk("if_id_hold", 32'(if_id_hold), 32'(e_hd));
      chk("halted", 32'(halted), 32'(e_hlt));
      chk("stall_err", 32'(stall_err), 32'(m_err));
      chk("redirect_cnt", 32'(redirect_cnt), 32'(e_r));
      chk("stall_cnt", 32'(stall_cnt), 32'(e_s));
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef PC_SEQ_STATS_EN
      return v;
`else
      return 32'h0 & v;
`endif
   endfunction

   initial begin
      tick(2);
      chk("lit_reset_pc", pc, 32'h0);
      chk("lit_reset_flush", 32'(if_id_flush), 32'd1);
      chk("lit_reset_we", 32'(pc_we), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("lit_first_pc", pc, 32'h0);
      chk("lit_first_we", 32'(pc_we), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("lit_seq_pc", pc, 32'(i));
      end
      tick(4);
      chk("lit_pc8", pc, 32'h8);

      jmp = 1'b1; npc_in = 32'h40; #1;
      chk("lit_jmp_flush", 32'(if_id_flush), 32'd1);
      tick(); jmp = 1'b0;
      chk("lit_jmp_pc", pc, 32'h40);
      chk("lit_redirect_cnt", 32'(redirect_cnt), stat(32'd1));

      stall = 1'b1; correct_b = 1'b1; npc_in = 32'h100; #1;
      chk("lit_stall_hold", 32'(if_id_hold), 32'd1);
      chk("lit_stall_noflush", 32'(if_id_flush), 32'd0);
      tick(2);
      chk("lit_stall_pc", pc, 32'h40);
      stall = 1'b0;
      tick(); correct_b = 1'b0;
      chk("lit_br_pc", pc, 32'h100);
      chk("lit_stall_cnt", 32'(stall_cnt), stat(32'd2));

      stall = 1'b1;
      tick(14);
      chk("lit_err_14", 32'(stall_err), 32'd0);
      tick();
      chk("lit_err_15", 32'(stall_err), 32'd1);
      stall = 1'b0;
      tick(3);
      chk("lit_err_sticky", 32'(stall_err), 32'd1);
      rst_n = 1'b0; #2;
      chk("lit_err_clr", 32'(stall_err), 32'd0);
      chk("lit_rst_pc", pc, 32'h0);
      tick(); rst_n = 1'b1;

      jmp = 1'b1; npc_in = 32'd20;
      tick(); jmp = 1'b0; halt_req = 1'b1;
      tick(); halt_req = 1'b0;
      chk("lit_halted", 32'(halted), 32'd1);
      chk("lit_halt_pc", pc, 32'd20);
      halt_req = 1'b1; tick(2); halt_req = 1'b0; tick(3);
      chk("lit_halt_hold_pc", pc, 32'd20);
      go = 1'b1;
      tick(); go = 1'b0;
      chk("lit_go_halted", 32'(halted), 32'd0);
      chk("lit_go_pc", pc, 32'd20);
      tick();
      chk("lit_resume_pc", pc, 32'd21);
      halt_req = 1'b1; tick(); halt_req = 1'b0; tick(2);
      rst_n = 1'b0; #2;
      chk("lit_halt_rst_pc", pc, 32'h0);
      chk("lit_halt_rst_halted", 32'(halted), 32'd0);
      tick(); rst_n = 1'b1;

      jmp = 1'b1; npc_in = 32'hFFFF_FFFF;
      tick(); jmp = 1'b0;
      chk("lit_max_pc", pc, 32'hFFFF_FFFF);
      chk("lit_wrap_plus", pc_plus, 32'h0);
      tick();
      chk("lit_wrap_pc", pc, 32'h0);
      tick(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
